// File: rtl/seq_divider.sv
// 4-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with quot=all-ones, rem=dividend.
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] quot,
  output logic [3:0] rem,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a request is accepted on any rising edge where state is IDLE
  // and start is high; done is a one-cycle result-valid pulse, no back-pressure.

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [4:0]  pr_q, pr_d;
  logic [3:0]  qacc_q, qacc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        dz_q, dz_d;

  logic [4:0]  shifted;
  logic        ge;
  logic [4:0]  step_pr;
  logic [3:0]  step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      pr_q    <= '0;
      qacc_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      qacc_q  <= qacc_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    // a_q doubles as the dividend shift register; its MSB is the next bit in.
    shifted = {pr_q[3:0], a_q[3]};
    ge      = (shifted >= {1'b0, b_q});
    step_pr = ge ? (shifted - {1'b0, b_q}) : shifted;
    step_q  = {qacc_q[2:0], ge};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pr_d    = pr_q;
    qacc_d  = qacc_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          pr_d   = '0;
          qacc_d = '0;
          cnt_d  = '0;
          if (b == 4'd0) begin
            state_d = DONE;
            quot_d  = 4'hF;
            rem_d   = a;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        pr_d   = step_pr;
        a_d    = {a_q[2:0], 1'b0};
        qacc_d = step_q;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          quot_d  = step_q;
          rem_d   = step_pr[3:0];
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_zero    = dz_q;
  assign dbg_state_o = state_q;

endmodule
